// File: rtl/arf192b080e1r1w0cbbehbaa4acw_gclk_rcb_ctrl_nch.sv
// Regional clock buffer controller: per-channel gated RCB clocks with
// idle hysteresis and staggered round-robin wake-up arbitration.

module arf192b080e1r1w0cbbehbaa4acw_rcb_and (
  input  logic clkb,
  input  logic en,
  input  logic fd,
  input  logic rd,
  output logic clkout
);
  logic enLat;
  logic lcpUnused;

  // fd/rd only tune edge placement in the physical cell
  assign lcpUnused = fd ^ rd;

  always_latch begin
    if (!clkb) enLat <= en;
  end

  assign clkout = clkb & enLat;
endmodule

module arf192b080e1r1w0cbbehbaa4acw_gclk_rcb_ctrl_nch #(
  parameter int NUM_CH   = 4,
  parameter int HYST_CNT = 8,
  parameter int HYST_W   = $clog2(HYST_CNT + 1),
  parameter int STAGGER  = 2
) (
  input  logic              CkGridX1N,
  input  logic              Rst,
  input  logic [NUM_CH-1:0] RPEn,
  input  logic [NUM_CH-1:0] RPOvrd,
  input  logic              FscanClkUngate,
  input  logic [NUM_CH-1:0] Fd,
  input  logic [NUM_CH-1:0] Rd,
  output logic [NUM_CH-1:0] CkRcbX1N,
  output logic [NUM_CH-1:0] RcbOn,
  output logic [NUM_CH-1:0] WakePend
);
  localparam int CW = (HYST_W < 1) ? 1 : HYST_W;
  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] HYST_LOAD =
    CW'((HYST_CNT > 0) ? HYST_CNT - 1 : 0);
  localparam logic [SW-1:0] STAG_LOAD = SW'(STAGGER - 1);

  typedef enum logic [1:0] {
    OFF,
    PEND,
    ON,
    HYST
  } stateT;

  stateT             st     [NUM_CH];
  stateT             stNxt  [NUM_CH];
  logic [CW-1:0]     cnt    [NUM_CH];
  logic [CW-1:0]     cntNxt [NUM_CH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptrNxt;
  logic [SW-1:0]     stag;
  logic [SW-1:0]     stagNxt;
  logic [NUM_CH-1:0] dmd;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;
  logic [NUM_CH-1:0] onNxt;
  logic [NUM_CH-1:0] pendNxt;
  logic              found;
  int                gntIdx;
  int                arbIdx;

  assign dmd = RPEn | RPOvrd;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      req[i] = dmd[i] & ~RPOvrd[i]
             & ((st[i] == OFF) | (st[i] == PEND));
    end
  end

  // Round-robin search starting at ptr, only once the stagger gap expires
  always_comb begin
    gnt    = '0;
    found  = 1'b0;
    gntIdx = 0;
    arbIdx = 0;
    if (stag == '0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        arbIdx = int'(ptr) + k;
        if (arbIdx >= NUM_CH) arbIdx = arbIdx - NUM_CH;
        if (!found && req[arbIdx]) begin
          found       = 1'b1;
          gntIdx      = arbIdx;
          gnt[arbIdx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptrNxt  = ptr;
    stagNxt = stag;
    if (stag != '0) stagNxt = stag - 1'b1;
    if (found) begin
      ptrNxt  = (gntIdx == NUM_CH - 1) ? '0 : PW'(gntIdx + 1);
      stagNxt = STAG_LOAD;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stNxt[i]  = st[i];
      cntNxt[i] = cnt[i];
      unique case (st[i])
        OFF: begin
          if (RPOvrd[i] || gnt[i]) stNxt[i] = ON;
          else if (req[i]) stNxt[i] = PEND;
        end
        PEND: begin
          if (RPOvrd[i]) stNxt[i] = ON;
          else if (!dmd[i]) stNxt[i] = OFF;
          else if (gnt[i]) stNxt[i] = ON;
        end
        ON: begin
          if (!dmd[i]) begin
            if (HYST_CNT == 0) begin
              stNxt[i] = OFF;
            end else begin
              stNxt[i]  = HYST;
              cntNxt[i] = HYST_LOAD;
            end
          end
        end
        HYST: begin
          if (dmd[i]) stNxt[i] = ON;
          else if (cnt[i] == '0) stNxt[i] = OFF;
          else cntNxt[i] = cnt[i] - 1'b1;
        end
        default: stNxt[i] = OFF;
      endcase
      onNxt[i]   = (stNxt[i] == ON) || (stNxt[i] == HYST);
      pendNxt[i] = (stNxt[i] == PEND);
    end
  end

  always_ff @(posedge CkGridX1N or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i]  <= OFF;
        cnt[i] <= '0;
      end
      ptr      <= '0;
      stag     <= '0;
      RcbOn    <= '0;
      WakePend <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i]  <= stNxt[i];
        cnt[i] <= cntNxt[i];
      end
      ptr      <= ptrNxt;
      stag     <= stagNxt;
      RcbOn    <= onNxt;
      WakePend <= pendNxt;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gRcb
    arf192b080e1r1w0cbbehbaa4acw_rcb_and uRcbAnd (
      .clkb  (CkGridX1N),
      .en    (RcbOn[g] | FscanClkUngate),
      .fd    (Fd[g]),
      .rd    (Rd[g]),
      .clkout(CkRcbX1N[g])
    );
  end
endmodule

// File: doc/arf192b080e1r1w0cbbehbaa4acw_gclk_rcb_ctrl_nch.md
# arf192b080e1r1w0cbbehbaa4acw_gclk_rcb_ctrl_nch

Multi-channel regional clock buffer controller for the array's clock tree: one gated RCB clock per channel from a shared grid clock. Per-channel power-enable demand passes through a state machine that adds idle hysteresis before gating and a round-robin staggered wake-up arbiter, limiting di/dt when several regions turn on together. Each channel drives one `arf192b080e1r1w0cbbehbaa4acw_rcb_and` cell, with its own Fd/Rd LCP bits. Scan ungate overrides all gating.

## Interface
- NUM_CH, 4: number of RCB channels; ≥1.
- HYST_CNT, 8: cycles a channel stays enabled after demand is first sampled low; 0 = gate at once.
- HYST_W, $clog2(HYST_CNT+1): hysteresis counter width (derived; do not override).
- STAGGER, 2: minimum grid cycles between successive arbitrated wake grants; ≥1.
- CkGridX1N  in  1  grid clock, free-running. All state updates on its rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- RPEn  in  NUM_CH  regional power enable per channel (Idle=0, Functional=1).
- RPOvrd  in  NUM_CH  regional power override per channel; forces the channel on without arbitration or hysteresis.
- FscanClkUngate  in  1  global scan ungate; combinational, not registered.
- Fd  in  NUM_CH  LCP bit per channel, passed to rcb_and.
- Rd  in  NUM_CH  LCP bit per channel, passed to rcb_and.
- CkRcbX1N  out  NUM_CH  gated RCB clock per channel.
- RcbOn  out  NUM_CH  registered; 1 while the channel's enable is asserted (state ON or HYST).
- WakePend  out  NUM_CH  registered; 1 while the channel waits for a wake grant (state PEND).

## Operation
- Demand: d[i] = RPEn[i] | RPOvrd[i].
- Per-channel FSM states: OFF, PEND, ON, HYST.
- Wake request: req[i] = d[i] & (state OFF or PEND) & ~RPOvrd[i].
- Arbiter:
  - Grants at most one req per edge, and only when stagger counter == 0.
  - Grants the first requesting channel at or after pointer `ptr`, searching upward with wrap.
  - On grant: ptr ← grant+1 mod NUM_CH; stagger counter ← STAGGER-1.
  - Stagger counter decrements every cycle while nonzero.
- OFF:
  - RPOvrd → ON.
  - Else req granted → ON.
  - Else req → PEND.
  - Else stay.
- PEND:
  - RPOvrd → ON.
  - Else ~d → OFF (request cancelled, no grant consumed).
  - Else granted → ON.
  - Else stay.
- ON:
  - d → stay.
  - ~d with HYST_CNT==0 → OFF.
  - ~d with HYST_CNT>0 → HYST, cnt ← HYST_CNT-1.
- HYST:
  - d → ON; no arbitration, no grant consumed.
  - Else cnt==0 → OFF.
  - Else cnt ← cnt-1.
- RcbOn[i] = state in {ON, HYST}.
- WakePend[i] = state==PEND.
- rcb_and per channel: clkb=CkGridX1N, en=RcbOn[i] | FscanClkUngate, fd=Fd[i], rd=Rd[i], clkout=CkRcbX1N[i].
- The enable latch inside the cell provides glitch-free gating; no extra latch in this block.

## Timing
- Reset (async assert, any time):
  - All FSMs OFF, counters 0.
  - RcbOn=0, WakePend=0, ptr=0, stagger counter=0.
  - CkRcbX1N is gated low unless FscanClkUngate=1.
- Reset deassertion: first evaluation at the next CkGridX1N rising edge.
- Uncontested wake: d sampled high at edge k, stagger counter 0 → RcbOn high after edge k. Latency 1 edge.
- Contested wake: the n-th channel served waits (n-1)·STAGGER further edges in PEND.
- Override wake: RPOvrd sampled high at edge k → ON after edge k, regardless of arbiter or stagger; ptr and stagger counter unchanged.
- Gate-off: ~d first sampled at edge k → RcbOn low after edge k+HYST_CNT, i.e. HYST_CNT cycles held.
- Re-demand in HYST: back to ON with no gap in RcbOn.
- Simultaneous RPOvrd and arbitrated wake on different channels, same edge: both go ON; the override does not block the grant.
- Mid-operation reset during HYST or PEND: immediate OFF; no pending state survives.
- FscanClkUngate=1: all CkRcbX1N follow CkGridX1N. The FSMs keep running and RcbOn is unaffected.

## Test plan
- Reset, NUM_CH=4, STAGGER=2:
  - Assert Rst → RcbOn=0000, WakePend=0000, CkRcbX1N low.
  - Also raise FscanClkUngate → all four clocks toggle.
- All-channel burst: RPEn=1111 at edge 0 → RcbOn bits set after edges 0, 2, 4, 6, in order ch0, ch1, ch2, ch3. WakePend shows the remaining waiters each cycle.
- Hysteresis, HYST_CNT=8:
  - Drop RPEn[1] at edge 10 → RcbOn[1] falls after edge 18.
  - Reassert at edge 15 → RcbOn[1] never falls.
- Override and cancel:
  - RPOvrd[3]=1 while ch3 in PEND → ON next edge.
  - RPEn[2] dropped while in PEND → OFF, and the next grant goes to the following channel without delay.
- Round-robin fairness: repeatedly toggle ch0 and ch2 requests after a grant to ch0 → ch2 is granted before ch0 again; ptr wraps from 3 to 0.
- Reset mid-HYST with HYST_CNT=8: assert Rst 3 cycles into HYST → RcbOn drops asynchronously; after release, the channel needs a fresh grant to wake.
